// File: rtl/map_pkg.sv
// ---------------------------------------------------------------------------
// map_pkg
// Shared definitions for the level sequencer and its goal-zone comparator:
//   - state_t        : sequencer FSM states
//   - DEFAULT_COORD_W: default pixel coordinate width
//   - map_rec_t      : one map entry {score_x, score_y, init_x, init_y}
//   - map_lookup()   : constant map table; indices past 3 repeat modulo 4
// ---------------------------------------------------------------------------
package map_pkg;

  localparam int DEFAULT_COORD_W = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY,
    ST_DWELL,
    ST_ADVANCE,
    ST_FINISH
  } state_t;

  typedef struct packed {
    logic [DEFAULT_COORD_W-1:0] score_x;
    logic [DEFAULT_COORD_W-1:0] score_y;
    logic [DEFAULT_COORD_W-1:0] init_x;
    logic [DEFAULT_COORD_W-1:0] init_y;
  } map_rec_t;

  // The table only has four distinct entries; larger tables cycle through them.
  function automatic map_rec_t map_lookup(input int unsigned idx);
    map_rec_t rec;
    unique case (idx % 32'd4)
      32'd0: begin
        rec.score_x = DEFAULT_COORD_W'(240);
        rec.score_y = DEFAULT_COORD_W'(240);
        rec.init_x  = DEFAULT_COORD_W'(60);
        rec.init_y  = DEFAULT_COORD_W'(60);
      end
      32'd1: begin
        rec.score_x = DEFAULT_COORD_W'(240);
        rec.score_y = DEFAULT_COORD_W'(450);
        rec.init_x  = DEFAULT_COORD_W'(50);
        rec.init_y  = DEFAULT_COORD_W'(38);
      end
      32'd2: begin
        rec.score_x = DEFAULT_COORD_W'(560);
        rec.score_y = DEFAULT_COORD_W'(80);
        rec.init_x  = DEFAULT_COORD_W'(80);
        rec.init_y  = DEFAULT_COORD_W'(400);
      end
      default: begin
        rec.score_x = DEFAULT_COORD_W'(600);
        rec.score_y = DEFAULT_COORD_W'(420);
        rec.init_x  = DEFAULT_COORD_W'(40);
        rec.init_y  = DEFAULT_COORD_W'(40);
      end
    endcase
    return rec;
  endfunction

endpackage

// File: rtl/goal_zone_cmp.sv
// ---------------------------------------------------------------------------
// goal_zone_cmp
// Combinational test of whether the ball lies inside the square goal zone
// centred on the score point. Also usable by the VGA highlight logic.
// Ports:
//   i_ballX, i_ballY   : ball position
//   i_scoreX, i_scoreY : goal centre
//   o_inZone           : 1 when |ball-score| <= HIT_RADIUS on both axes
// ---------------------------------------------------------------------------
module goal_zone_cmp
  import map_pkg::*;
#(
  parameter int COORD_W    = DEFAULT_COORD_W,
  parameter int HIT_RADIUS = 16
) (
  input  logic [COORD_W-1:0] i_ballX,
  input  logic [COORD_W-1:0] i_ballY,
  input  logic [COORD_W-1:0] i_scoreX,
  input  logic [COORD_W-1:0] i_scoreY,
  output logic               o_inZone
);

  logic [COORD_W:0] w_dx;
  logic [COORD_W:0] w_dy;

  // Magnitudes are formed one bit wider and always as larger-minus-smaller,
  // so positions near 0 or the top of the range never wrap into the zone.
  always_comb begin
    if (i_ballX >= i_scoreX) w_dx = {1'b0, i_ballX} - {1'b0, i_scoreX};
    else                     w_dx = {1'b0, i_scoreX} - {1'b0, i_ballX};
    if (i_ballY >= i_scoreY) w_dy = {1'b0, i_ballY} - {1'b0, i_scoreY};
    else                     w_dy = {1'b0, i_scoreY} - {1'b0, i_ballY};
  end

  assign o_inZone = (w_dx <= (COORD_W+1)'(HIT_RADIUS)) &&
                    (w_dy <= (COORD_W+1)'(HIT_RADIUS));

endmodule

// File: rtl/map_sequencer.sv
// ---------------------------------------------------------------------------
// map_sequencer
// Walks through a constant table of maps: loads a map's coordinates, spawns
// the ball, waits for DWELL_SAMPLES consecutive valid in-zone samples, then
// advances (wrapping or finishing depending on WRAP).
// Optional feature macro: MAP_SEQUENCER_TIMER_EN adds a per-attempt timeout of
// TIME_LIMIT cycles that respawns the ball on the current map.
// Ports:
//   clk, rst (sync, active-low)
//   start, restart                  : control pulses
//   ball_x, ball_y, ball_valid      : ball position samples
//   map_idx                         : current map
//   score_x/y, init_x/y             : registered goal / spawn coordinates
//   spawn, level_done, time_up      : one-cycle pulses
//   playing, all_done               : level status
// ---------------------------------------------------------------------------
module map_sequencer
  import map_pkg::*;
#(
  parameter int NUM_MAPS      = 4,
  parameter int COORD_W       = DEFAULT_COORD_W,
  parameter int HIT_RADIUS    = 16,
  parameter int DWELL_SAMPLES = 8,
  parameter int WRAP          = 1,
  parameter int TIME_LIMIT    = 3000000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        restart,
  input  logic [COORD_W-1:0]          ball_x,
  input  logic [COORD_W-1:0]          ball_y,
  input  logic                        ball_valid,
  output logic [$clog2(NUM_MAPS)-1:0] map_idx,
  output logic [COORD_W-1:0]          score_x,
  output logic [COORD_W-1:0]          score_y,
  output logic [COORD_W-1:0]          init_x,
  output logic [COORD_W-1:0]          init_y,
  output logic                        spawn,
  output logic                        playing,
  output logic                        level_done,
  output logic                        all_done,
  output logic                        time_up
);

  localparam int IDX_W = $clog2(NUM_MAPS);
  localparam int CNT_W = $clog2(DWELL_SAMPLES + 1);
  localparam map_rec_t RESET_REC = map_lookup(0);

  state_t             r_state;
  state_t             w_nextState;
  logic [IDX_W-1:0]   r_mapIdx;
  logic [IDX_W-1:0]   w_nextIdx;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_nextCount;
  logic [COORD_W-1:0] r_scoreX;
  logic [COORD_W-1:0] r_scoreY;
  logic [COORD_W-1:0] r_initX;
  logic [COORD_W-1:0] r_initY;
  logic               r_spawn;
  logic               w_inZone;
  logic               w_timeout;
  logic               w_levelDone;
  logic               w_timeUp;
  map_rec_t           w_mapRec;

  assign w_mapRec = map_lookup(32'(r_mapIdx));

  goal_zone_cmp #(
    .COORD_W    (COORD_W),
    .HIT_RADIUS (HIT_RADIUS)
  ) u_zone (
    .i_ballX  (ball_x),
    .i_ballY  (ball_y),
    .i_scoreX (r_scoreX),
    .i_scoreY (r_scoreY),
    .o_inZone (w_inZone)
  );

`ifdef MAP_SEQUENCER_TIMER_EN
  localparam int TMR_W = $clog2(TIME_LIMIT + 1);
  logic [TMR_W-1:0] r_timer;

  // Attempt timer: reloaded on every (re)load, counts down while playing.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_timer <= '0;
    end else if (r_state == ST_LOAD) begin
      r_timer <= TMR_W'(TIME_LIMIT - 1);
    end else if ((r_state == ST_PLAY || r_state == ST_DWELL) && r_timer != '0) begin
      r_timer <= r_timer - 1'b1;
    end
  end

  assign w_timeout = (r_timer == '0);
`else
  logic [31:0] w_unusedTimeLimit;
  assign w_unusedTimeLimit = 32'(TIME_LIMIT);
  assign w_timeout = 1'b0;
`endif

  // State, map index and dwell counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_mapIdx <= '0;
      r_count  <= '0;
    end else begin
      r_state  <= w_nextState;
      r_mapIdx <= w_nextIdx;
      r_count  <= w_nextCount;
    end
  end

  // Coordinates are captured in LOAD so they are stable from the spawn cycle;
  // spawn is simply "last cycle was LOAD", since LOAD always moves to PLAY.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_scoreX <= COORD_W'(RESET_REC.score_x);
      r_scoreY <= COORD_W'(RESET_REC.score_y);
      r_initX  <= COORD_W'(RESET_REC.init_x);
      r_initY  <= COORD_W'(RESET_REC.init_y);
      r_spawn  <= 1'b0;
    end else begin
      if (r_state == ST_LOAD) begin
        r_scoreX <= COORD_W'(w_mapRec.score_x);
        r_scoreY <= COORD_W'(w_mapRec.score_y);
        r_initX  <= COORD_W'(w_mapRec.init_x);
        r_initY  <= COORD_W'(w_mapRec.init_y);
      end
      r_spawn <= (r_state == ST_LOAD);
    end
  end

  // Next-state logic. In PLAY the count is always zero, so PLAY and DWELL
  // share one path; restart beats timeout, which beats ball samples.
  always_comb begin
    w_nextState = r_state;
    w_nextIdx   = r_mapIdx;
    w_nextCount = r_count;
    w_levelDone = 1'b0;
    w_timeUp    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) w_nextState = ST_LOAD;
      end
      ST_LOAD: begin
        w_nextState = ST_PLAY;
      end
      ST_PLAY, ST_DWELL: begin
        if (restart) begin
          w_nextState = ST_LOAD;
          w_nextCount = '0;
        end else if (w_timeout) begin
          w_timeUp    = 1'b1;
          w_nextState = ST_LOAD;
          w_nextCount = '0;
        end else if (ball_valid) begin
          if (w_inZone) begin
            if (int'(r_count) + 1 >= DWELL_SAMPLES) begin
              w_nextState = ST_ADVANCE;
              w_nextCount = '0;
            end else begin
              w_nextState = ST_DWELL;
              w_nextCount = r_count + 1'b1;
            end
          end else begin
            w_nextState = ST_PLAY;
            w_nextCount = '0;
          end
        end
      end
      ST_ADVANCE: begin
        w_nextCount = '0;
        if (restart) begin
          w_nextState = ST_LOAD;
        end else begin
          w_levelDone = 1'b1;
          if (int'(r_mapIdx) < NUM_MAPS - 1) begin
            w_nextIdx   = r_mapIdx + 1'b1;
            w_nextState = ST_LOAD;
          end else if (WRAP != 0) begin
            w_nextIdx   = '0;
            w_nextState = ST_LOAD;
          end else begin
            w_nextState = ST_FINISH;
          end
        end
      end
      ST_FINISH: begin
        if (start) begin
          w_nextIdx   = '0;
          w_nextState = ST_LOAD;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  assign map_idx    = r_mapIdx;
  assign score_x    = r_scoreX;
  assign score_y    = r_scoreY;
  assign init_x     = r_initX;
  assign init_y     = r_initY;
  assign spawn      = r_spawn;
  assign playing    = (r_state == ST_PLAY) || (r_state == ST_DWELL);
  assign level_done = w_levelDone;
  assign all_done   = (r_state == ST_FINISH);
  assign time_up    = w_timeUp;

endmodule

// File: tb/tb_map_sequencer.sv
// ---------------------------------------------------------------------------
// tb_map_sequencer
// Main instance: 4 maps, 8 dwell samples, wrapping, 100-cycle attempt limit.
// Second instance: 2 maps, 1 dwell sample, no wrap, driven from a table of
// ball offsets around the current goal.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_map_sequencer;
  import map_pkg::*;

  localparam int CW = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic          start, restart, ballValid;
  logic [CW-1:0] ballX, ballY;
  logic [1:0]    mapIdx;
  logic [CW-1:0] scoreX, scoreY, initX, initY;
  logic          spawn, playing, levelDone, allDone, timeUp;

  logic          bStart, bRestart, bValid;
  logic [CW-1:0] bBallX, bBallY;
  logic [0:0]    bMapIdx;
  logic [CW-1:0] bScoreX, bScoreY, bInitX, bInitY;
  logic          bSpawn, bPlaying, bLevelDone, bAllDone, bTimeUp;

  int errors = 0;
  int checks = 0;

  int tScoreX [4] = '{240, 240, 560, 600};
  int tScoreY [4] = '{240, 450, 80, 420};
  int tInitX  [4] = '{60, 50, 80, 40};
  int tInitY  [4] = '{60, 38, 400, 40};

  typedef struct {
    int idx;
    int ix;
    int iy;
    int sx;
    int sy;
  } spawn_t;
  spawn_t spawnQ[$];

  typedef struct {
    int dx;
    int dy;
    int hit;
  } vec_t;
  vec_t vecs [10];

  map_sequencer #(
    .NUM_MAPS(4), .COORD_W(CW), .HIT_RADIUS(16), .DWELL_SAMPLES(8),
    .WRAP(1), .TIME_LIMIT(100)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .restart(restart),
    .ball_x(ballX), .ball_y(ballY), .ball_valid(ballValid),
    .map_idx(mapIdx), .score_x(scoreX), .score_y(scoreY),
    .init_x(initX), .init_y(initY), .spawn(spawn), .playing(playing),
    .level_done(levelDone), .all_done(allDone), .time_up(timeUp)
  );

  map_sequencer #(
    .NUM_MAPS(2), .COORD_W(CW), .HIT_RADIUS(16), .DWELL_SAMPLES(1),
    .WRAP(0), .TIME_LIMIT(3000000)
  ) dut2 (
    .clk(clk), .rst(rst), .start(bStart), .restart(bRestart),
    .ball_x(bBallX), .ball_y(bBallY), .ball_valid(bValid),
    .map_idx(bMapIdx), .score_x(bScoreX), .score_y(bScoreY),
    .init_x(bInitX), .init_y(bInitY), .spawn(bSpawn), .playing(bPlaying),
    .level_done(bLevelDone), .all_done(bAllDone), .time_up(bTimeUp)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushSpawn(input int idx);
    spawn_t e;
    e.idx = idx;
    e.ix  = tInitX[idx];
    e.iy  = tInitY[idx];
    e.sx  = tScoreX[idx];
    e.sy  = tScoreY[idx];
    spawnQ.push_back(e);
  endtask

  // Every spawn pulse of the main instance is matched against the queue.
  always @(negedge clk) begin
    spawn_t e;
    if (rst === 1'b1 && spawn === 1'b1) begin
      if (spawnQ.size() == 0) begin
        checkOutput("unexpectedSpawn", 1, 0);
      end else begin
        e = spawnQ.pop_front();
        checkOutput("spawnMapIdx", int'(mapIdx), e.idx);
        checkOutput("spawnInitX", int'(initX), e.ix);
        checkOutput("spawnInitY", int'(initY), e.iy);
        checkOutput("spawnScoreX", int'(scoreX), e.sx);
        checkOutput("spawnScoreY", int'(scoreY), e.sy);
      end
    end
  end

  // Hold the ball at (x,y) with valid for n cycles; level_done must stay low
  // until the last sample, where it must equal lastDone.
  task automatic feed(input int n, input int x, input int y, input int lastDone);
    ballX = CW'(x);
    ballY = CW'(y);
    ballValid = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      if (i == n - 1) checkOutput("doneOnLastSample", int'(levelDone), lastDone);
      else            checkOutput("noEarlyDone", int'(levelDone), 0);
    end
    ballValid = 1'b0;
  endtask

  // One table vector on the single-sample instance.
  task automatic applyStimulus(input int i, inout int m2);
    bBallX = CW'(tScoreX[m2] + vecs[i].dx);
    bBallY = CW'(tScoreY[m2] + vecs[i].dy);
    bValid = 1'b1;
    tick();
    bValid = 1'b0;
    checkOutput($sformatf("vecDone%0d", i), int'(bLevelDone), vecs[i].hit);
    if (vecs[i].hit != 0) begin
      if (m2 == 0) begin
        tick();
        tick();
        checkOutput("vecSpawnMap1", int'(bSpawn), 1);
        checkOutput("vecMapIdx1", int'(bMapIdx), 1);
        checkOutput("vecScoreY1", int'(bScoreY), 450);
        m2 = 1;
      end else begin
        tick();
        checkOutput("finishAllDone", int'(bAllDone), 1);
        bRestart = 1'b1;
        tick();
        bRestart = 1'b0;
        checkOutput("finishRestartIgnored", int'(bAllDone), 1);
        bStart = 1'b1;
        tick();
        bStart = 1'b0;
        checkOutput("finishStartClears", int'(bAllDone), 0);
        checkOutput("finishIdxZero", int'(bMapIdx), 0);
        tick();
        checkOutput("finishRespawn", int'(bSpawn), 1);
        checkOutput("finishInitX", int'(bInitX), 60);
        checkOutput("finishInitY", int'(bInitY), 60);
        m2 = 0;
      end
    end else begin
      checkOutput($sformatf("vecStillPlaying%0d", i), int'(bPlaying), 1);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int m2;
    int n;

    vecs[0] = '{dx: 0,   dy: 0,   hit: 1};
    vecs[1] = '{dx: 17,  dy: 0,   hit: 0};
    vecs[2] = '{dx: 16,  dy: -16, hit: 1};
    vecs[3] = '{dx: -17, dy: 5,   hit: 0};
    vecs[4] = '{dx: -16, dy: 16,  hit: 1};
    vecs[5] = '{dx: 0,   dy: 17,  hit: 0};
    vecs[6] = '{dx: 3,   dy: -17, hit: 0};
    vecs[7] = '{dx: 16,  dy: 0,   hit: 1};
    vecs[8] = '{dx: 0,   dy: -16, hit: 1};
    vecs[9] = '{dx: -5,  dy: 9,   hit: 1};

    rst = 1'b0;
    start = 1'b0; restart = 1'b0; ballValid = 1'b0; ballX = '0; ballY = '0;
    bStart = 1'b0; bRestart = 1'b0; bValid = 1'b0; bBallX = '0; bBallY = '0;
    tick();
    tick();
    checkOutput("rstMapIdx", int'(mapIdx), 0);
    checkOutput("rstScoreX", int'(scoreX), 240);
    checkOutput("rstScoreY", int'(scoreY), 240);
    checkOutput("rstInitX", int'(initX), 60);
    checkOutput("rstInitY", int'(initY), 60);
    checkOutput("rstSpawn", int'(spawn), 0);
    checkOutput("rstPlaying", int'(playing), 0);
    checkOutput("rstLevelDone", int'(levelDone), 0);
    checkOutput("rstAllDone", int'(allDone), 0);
    checkOutput("rstTimeUp", int'(timeUp), 0);
    rst = 1'b1;

    $display("[TB] start and first level");
    pushSpawn(0);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("loadNoSpawn", int'(spawn), 0);
    checkOutput("loadNotPlaying", int'(playing), 0);
    tick();
    checkOutput("spawnLatency", int'(spawn), 1);
    checkOutput("playingAfterSpawn", int'(playing), 1);

    pushSpawn(1);
    feed(8, 250, 230, 1);
    tick();
    checkOutput("advanceIdx", int'(mapIdx), 1);
    checkOutput("loadNotPlaying2", int'(playing), 0);
    tick();
    checkOutput("spawnMap1", int'(spawn), 1);

    $display("[TB] zone edge and dwell reset");
    feed(10, 257, 450, 0);
    checkOutput("outOfZonePlaying", int'(playing), 1);
    checkOutput("outOfZoneIdx", int'(mapIdx), 1);
    feed(5, 250, 440, 0);
    feed(1, 300, 300, 0);
    pushSpawn(2);
    feed(8, 240, 450, 1);
    tick();
    tick();
    checkOutput("spawnMap2", int'(spawn), 1);

    $display("[TB] restart on completing sample");
    feed(7, 565, 75, 0);
    pushSpawn(2);
    ballValid = 1'b1;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    ballValid = 1'b0;
    checkOutput("restartNoDone", int'(levelDone), 0);
    checkOutput("restartSameIdx", int'(mapIdx), 2);
    checkOutput("restartInLoad", int'(playing), 0);
    tick();
    checkOutput("restartSpawn", int'(spawn), 1);

    $display("[TB] wrap to map 0");
    pushSpawn(3);
    feed(8, 560, 80, 1);
    tick();
    tick();
    checkOutput("spawnMap3", int'(spawn), 1);
    pushSpawn(0);
    feed(8, 600, 420, 1);
    tick();
    checkOutput("wrapIdx", int'(mapIdx), 0);
    checkOutput("wrapNoAllDone", int'(allDone), 0);
    tick();
    checkOutput("wrapSpawn", int'(spawn), 1);

    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("startIgnoredPlaying", int'(playing), 1);
    checkOutput("startIgnoredNoSpawn", int'(spawn), 0);
    tick();
    checkOutput("startIgnoredNoSpawn2", int'(spawn), 0);

    $display("[TB] reset during dwell");
    pushSpawn(1);
    feed(8, 240, 240, 1);
    tick();
    tick();
    checkOutput("spawnMap1Again", int'(spawn), 1);
    feed(3, 240, 450, 0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checkOutput("midRstIdx", int'(mapIdx), 0);
    checkOutput("midRstScoreY", int'(scoreY), 240);
    checkOutput("midRstInitX", int'(initX), 60);
    checkOutput("midRstInitY", int'(initY), 60);
    checkOutput("midRstPlaying", int'(playing), 0);
    checkOutput("midRstSpawn", int'(spawn), 0);
    checkOutput("midRstLevelDone", int'(levelDone), 0);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    tick();
    tick();
    checkOutput("idleRestartIgnored", int'(playing), 0);
    checkOutput("idleRestartNoSpawn", int'(spawn), 0);

`ifdef MAP_SEQUENCER_TIMER_EN
    $display("[TB] attempt timeout");
    pushSpawn(0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checkOutput("timerSpawn", int'(spawn), 1);
    n = 0;
    while (timeUp !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    checkOutput("timeUpDelay", n, 99);
    pushSpawn(0);
    tick();
    checkOutput("timeUpPulse", int'(timeUp), 0);
    checkOutput("timeUpSameIdx", int'(mapIdx), 0);
    tick();
    checkOutput("timeUpRespawn", int'(spawn), 1);
`else
    n = 0;
`endif

    $display("[TB] single-sample table, no wrap");
    bStart = 1'b1;
    tick();
    bStart = 1'b0;
    tick();
    checkOutput("bFirstSpawn", int'(bSpawn), 1);
    m2 = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(i, m2);
    end

    checkOutput("spawnQueueEmpty", spawnQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
